// File: rtl/seq4_result_checker.sv
// Group-of-four result checker.
// Collects four stimulus samples, computes their unsigned maximum as a reference, then waits
// a bounded number of cycles for the DUT to report its own maximum and scores the outcome.
module seq4_result_checker #(
   parameter int unsigned DW      = 3,
   parameter int unsigned TIMEOUT = 4   // legal range 1..15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          dut_valid,
   input  logic [DW-1:0] dut_max,
   output logic          group_done,
   output logic [DW-1:0] ref_max,
   output logic          pass,
   output logic          mismatch,
   output logic          timeout,
   output logic          spurious,
   output logic [7:0]    err_count,
   output logic [7:0]    group_count
);

   localparam logic S_COLLECT = 1'b0;
   localparam logic S_WAIT    = 1'b1;

   // Timer value seen on the last allowed WAIT_DUT cycle.
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   logic          state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [DW-1:0] run_max_q, run_max_d;
   logic [3:0]    timer_q, timer_d;
   logic [DW-1:0] ref_max_q, ref_max_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [7:0]    group_count_q, group_count_d;
   logic          group_done_q, group_done_d;
   logic          pass_q, pass_d;
   logic          mismatch_q, mismatch_d;
   logic          timeout_q, timeout_d;
   logic          spurious_q, spurious_d;

   logic          accept;
   logic          err_inc;
   logic [DW-1:0] max_next;

   assign in_ready = (state_q == S_COLLECT);
   assign accept   = in_valid && in_ready;

   // The first sample of a group loads the max; later ones replace it only if strictly greater.
   assign max_next = ((idx_q == 2'd0) || (in_data > run_max_q)) ? in_data : run_max_q;

   // Next-state: sample collection, result scoring and event generation.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      run_max_d     = run_max_q;
      timer_d       = timer_q;
      ref_max_d     = ref_max_q;
      group_count_d = group_count_q;
      group_done_d  = 1'b0;
      pass_d        = 1'b0;
      mismatch_d    = 1'b0;
      timeout_d     = 1'b0;
      spurious_d    = 1'b0;
      err_inc       = 1'b0;

      unique case (state_q)
         S_COLLECT: begin
            // A result with nothing outstanding is an error but does not disturb collection.
            if (dut_valid) begin
               spurious_d = 1'b1;
               err_inc    = 1'b1;
            end
            if (accept) begin
               run_max_d = max_next;
               idx_d     = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  ref_max_d     = max_next;
                  group_done_d  = 1'b1;
                  group_count_d = group_count_q + 8'd1;
                  idx_d         = 2'd0;
                  timer_d       = 4'd0;
                  state_d       = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // A result arriving on the final allowed cycle beats the timeout.
            if (dut_valid) begin
               if (dut_max == ref_max_q) begin
                  pass_d = 1'b1;
               end else begin
                  mismatch_d = 1'b1;
                  err_inc    = 1'b1;
               end
               state_d = S_COLLECT;
            end else if (timer_q == TO_LAST) begin
               timeout_d = 1'b1;
               err_inc   = 1'b1;
               state_d   = S_COLLECT;
            end else begin
               timer_d = timer_q + 4'd1;
            end
         end
      endcase

      err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
   end

   // State and event registers; reset discards any partial group or pending wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_COLLECT;
         idx_q         <= 2'd0;
         run_max_q     <= '0;
         timer_q       <= 4'd0;
         ref_max_q     <= '0;
         err_count_q   <= 8'd0;
         group_count_q <= 8'd0;
         group_done_q  <= 1'b0;
         pass_q        <= 1'b0;
         mismatch_q    <= 1'b0;
         timeout_q     <= 1'b0;
         spurious_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         run_max_q     <= run_max_d;
         timer_q       <= timer_d;
         ref_max_q     <= ref_max_d;
         err_count_q   <= err_count_d;
         group_count_q <= group_count_d;
         group_done_q  <= group_done_d;
         pass_q        <= pass_d;
         mismatch_q    <= mismatch_d;
         timeout_q     <= timeout_d;
         spurious_q    <= spurious_d;
      end
   end

   assign group_done  = group_done_q;
   assign ref_max     = ref_max_q;
   assign pass        = pass_q;
   assign mismatch    = mismatch_q;
   assign timeout     = timeout_q;
   assign spurious    = spurious_q;
   assign err_count   = err_count_q;
   assign group_count = group_count_q;

endmodule

// File: tb/tb_seq4_result_checker.sv
// Self-checking bench for seq4_result_checker: behavioural model plus directed literal checks
// followed by randomized traffic.
module tb_seq4_result_checker;

   localparam int DW      = 3;
   localparam int TIMEOUT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          dut_valid = 1'b0;
   logic [DW-1:0] dut_max = '0;
   logic          group_done;
   logic [DW-1:0] ref_max;
   logic          pass;
   logic          mismatch;
   logic          timeout;
   logic          spurious;
   logic [7:0]    err_count;
   logic [7:0]    group_count;

   int tests = 0;
   int fails = 0;

   seq4_result_checker #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .dut_valid   (dut_valid),
      .dut_max     (dut_max),
      .group_done  (group_done),
      .ref_max     (ref_max),
      .pass        (pass),
      .mismatch    (mismatch),
      .timeout     (timeout),
      .spurious    (spurious),
      .err_count   (err_count),
      .group_count (group_count)
   );

   always #5 clk = ~clk;

   // Model state: samples of the open group, waiting flag, cycles waited, expected outputs.
   int grp[$];
   bit m_wait;
   int m_waited;
   int m_ref, m_err, m_gcnt, mx;
   bit m_gd, m_pass, m_mis, m_to, m_sp;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Literal expectation checked against both the DUT and the model.
   task automatic lit(input string name, input int act, input int mdl, input int exp);
      chk({name, "_dut"}, act, exp);
      chk({name, "_model"}, mdl, exp);
   endtask

   // Behavioural reference model.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         grp.delete();
         m_wait = 0; m_waited = 0; m_ref = 0; m_err = 0; m_gcnt = 0;
         m_gd = 0; m_pass = 0; m_mis = 0; m_to = 0; m_sp = 0;
      end else begin
         m_gd = 0; m_pass = 0; m_mis = 0; m_to = 0; m_sp = 0;
         if (!m_wait) begin
            if (dut_valid) begin
               m_sp = 1;
               if (m_err < 255) m_err++;
            end
            if (in_valid) begin
               grp.push_back(int'(in_data));
               if (grp.size() == 4) begin
                  mx = 0;
                  foreach (grp[i]) if (grp[i] > mx) mx = grp[i];
                  m_ref = mx;
                  m_gd = 1;
                  m_gcnt = (m_gcnt + 1) % 256;
                  grp.delete();
                  m_wait = 1;
                  m_waited = 0;
               end
            end
         end else if (dut_valid) begin
            if (int'(dut_max) == m_ref) m_pass = 1;
            else begin
               m_mis = 1;
               if (m_err < 255) m_err++;
            end
            m_wait = 0;
         end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
               m_to = 1;
               if (m_err < 255) m_err++;
               m_wait = 0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(posedge clk);
      #2;
      chk("in_ready", int'(in_ready), int'(!m_wait));
      chk("group_done", int'(group_done), int'(m_gd));
      chk("ref_max", int'(ref_max), m_ref);
      chk("pass", int'(pass), int'(m_pass));
      chk("mismatch", int'(mismatch), int'(m_mis));
      chk("timeout", int'(timeout), int'(m_to));
      chk("spurious", int'(spurious), int'(m_sp));
      chk("err_count", int'(err_count), m_err);
      chk("group_count", int'(group_count), m_gcnt);
   end

   // Apply inputs for one clock edge; returns at the following negedge.
   task automatic cyc(input bit iv, input int d, input bit dv, input int dm);
      in_valid  = iv;
      in_data   = d[DW-1:0];
      dut_valid = dv;
      dut_max   = dm[DW-1:0];
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 0;
      dut_valid = 0;
      rst_n     = 0;
      @(negedge clk);
      lit("rst_in_ready", int'(in_ready), int'(!m_wait), 1);
      lit("rst_ref_max", int'(ref_max), m_ref, 0);
      lit("rst_err", int'(err_count), m_err, 0);
      lit("rst_gcnt", int'(group_count), m_gcnt, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int iv, dv, d, dm;
      @(negedge clk);
      do_reset();

      // Back-to-back group, correct result.
      cyc(1, 5, 0, 0); cyc(1, 4, 0, 0); cyc(1, 3, 0, 0); cyc(1, 2, 0, 0);
      lit("g1_done", int'(group_done), int'(m_gd), 1);
      lit("g1_ref", int'(ref_max), m_ref, 5);
      lit("g1_ready", int'(in_ready), int'(!m_wait), 0);
      cyc(0, 0, 1, 5);
      lit("g1_pass", int'(pass), int'(m_pass), 1);
      lit("g1_err", int'(err_count), m_err, 0);
      lit("g1_gcnt", int'(group_count), m_gcnt, 1);
      lit("g1_ready_back", int'(in_ready), int'(!m_wait), 1);

      // Wrong result.
      do_reset();
      cyc(1, 1, 0, 0); cyc(1, 6, 0, 0); cyc(1, 6, 0, 0); cyc(1, 0, 0, 0);
      lit("g2_ref", int'(ref_max), m_ref, 6);
      lit("g2_ready0", int'(in_ready), int'(!m_wait), 0);
      cyc(0, 0, 0, 0);
      lit("g2_ready1", int'(in_ready), int'(!m_wait), 0);
      cyc(0, 0, 1, 4);
      lit("g2_mis", int'(mismatch), int'(m_mis), 1);
      lit("g2_err", int'(err_count), m_err, 1);
      lit("g2_ready2", int'(in_ready), int'(!m_wait), 1);

      // Timeout after TIMEOUT idle wait cycles.
      do_reset();
      cyc(1, 7, 0, 0); cyc(1, 0, 0, 0); cyc(1, 7, 0, 0); cyc(1, 3, 0, 0);
      lit("g3_ref", int'(ref_max), m_ref, 7);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      lit("g3_no_to", int'(timeout), int'(m_to), 0);
      lit("g3_wait", int'(in_ready), int'(!m_wait), 0);
      cyc(0, 0, 0, 0);
      lit("g3_to", int'(timeout), int'(m_to), 1);
      lit("g3_err", int'(err_count), m_err, 1);
      lit("g3_ready", int'(in_ready), int'(!m_wait), 1);

      // Result arriving while collecting.
      do_reset();
      cyc(1, 3, 0, 0); cyc(1, 5, 0, 0);
      cyc(0, 0, 1, 2);
      lit("g4_spur", int'(spurious), int'(m_sp), 1);
      lit("g4_err", int'(err_count), m_err, 1);
      cyc(1, 2, 0, 0); cyc(1, 1, 0, 0);
      lit("g4_done", int'(group_done), int'(m_gd), 1);
      lit("g4_ref", int'(ref_max), m_ref, 5);
      cyc(0, 0, 1, 5);

      // Reset mid-group discards the partial samples.
      do_reset();
      cyc(1, 6, 0, 0); cyc(1, 6, 0, 0); cyc(1, 6, 0, 0);
      do_reset();
      cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
      lit("g5_ref", int'(ref_max), m_ref, 4);
      lit("g5_gcnt", int'(group_count), m_gcnt, 1);
      lit("g5_err", int'(err_count), m_err, 0);
      cyc(0, 0, 1, 4);

      // Error counter saturation and group counter wrap.
      do_reset();
      for (int g = 0; g < 260; g++) begin
         cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
         cyc(0, 0, 1, 2);
         chk("sat_mismatch", int'(mismatch), 1);
      end
      lit("sat_err", int'(err_count), m_err, 255);
      lit("sat_gcnt", int'(group_count), m_gcnt, 4);

      // Randomized traffic, occasionally resetting.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(399) == 0) begin
            do_reset();
         end else begin
            iv = ($urandom_range(9) < 7) ? 1 : 0;
            d  = int'($urandom_range(7));
            if (m_wait) dv = ($urandom_range(3) == 0) ? 1 : 0;
            else        dv = ($urandom_range(19) == 0) ? 1 : 0;
            dm = ($urandom_range(1) == 0) ? m_ref : int'($urandom_range(7));
            cyc(iv[0], d, dv[0], dm);
         end
      end
      cyc(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
